// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP test-frame generator: FSM states,
// pattern encodings, RGB565 bar colours and default video timing.
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } state_t;

  localparam logic [1:0] PAT_BARS     = 2'b00;
  localparam logic [1:0] PAT_GRAD     = 2'b01;
  localparam logic [1:0] PAT_CHECK    = 2'b10;
  localparam logic [1:0] PAT_FRAME_ID = 2'b11;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_H_BLANK  = 288;
  localparam int unsigned DEF_V_SYNC   = 3;
  localparam int unsigned DEF_V_BP     = 17;
  localparam int unsigned DEF_V_FP     = 10;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dvp_pattern.sv
// Combinational test-pattern source: maps pattern select, pixel column,
// active line and frame count to one RGB565 pixel.
module dvp_pattern
  import dvp_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 6
) (
  input  logic [1:0]    sel,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [7:0]    frame_count,
  output logic [15:0]   pixel_c
);

  localparam int unsigned BAR_PX = H_ACTIVE / 8;

  logic [2:0] bar_idx;
  logic       unused_y;

  assign bar_idx  = 3'(x / XW'(BAR_PX));
  assign unused_y = ^y;

  always_comb begin
    pixel_c = 16'h0000;
    case (sel)
      PAT_BARS:  pixel_c = bar_color(bar_idx);
      PAT_GRAD:  pixel_c = {x[9:5], x[9:4], x[9:5]};
      PAT_CHECK: pixel_c = (x[5] ^ y[5]) ? 16'hFFFF : 16'h0000;
      default:   pixel_c = {frame_count, ~frame_count};
    endcase
  end

endmodule

// File: rtl/dvp_frame_gen.sv
// DVP camera frame generator: vsync/back-porch/active/front-porch timing FSM
// with line and column counters, driving a registered RGB565 byte stream.
module dvp_frame_gen
  import dvp_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned H_BLANK  = DEF_H_BLANK,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_FP     = DEF_V_FP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       cam_vsync,
  output logic       cam_href,
  output logic [7:0] cam_data,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  localparam int unsigned HREF_LEN = 2 * H_ACTIVE;
  localparam int unsigned LINE_LEN = HREF_LEN + H_BLANK;
  localparam int unsigned COL_W    = max2($clog2(LINE_LEN), 1);
  localparam int unsigned V_MAX    = max2(max2(V_SYNC, V_BP), max2(V_ACTIVE, V_FP));
  localparam int unsigned LINE_W   = max2($clog2(V_MAX), 1);
  localparam int unsigned PXW      = max2($clog2(H_ACTIVE), 10);
  localparam int unsigned PYW      = max2($clog2(V_ACTIVE), 6);

  state_t              state_q, state_nxt;
  logic [COL_W-1:0]    col_q, col_nxt;
  logic [LINE_W-1:0]   line_q, line_nxt;
  logic [1:0]          sel_q;
  logic                eol, last_line, sel_load;
  logic                href_nxt, done_nxt;
  logic [7:0]          data_nxt;
  logic [PXW-1:0]      x_nxt;
  logic [PYW-1:0]      y_nxt;
  logic [15:0]         pixel_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  assign eol = (col_q == COL_W'(LINE_LEN - 1));

  always_comb begin
    last_line = 1'b0;
    case (state_q)
      ST_VSYNC:  last_line = (line_q == LINE_W'(V_SYNC - 1));
      ST_VBP:    last_line = (line_q == LINE_W'(V_BP - 1));
      ST_ACTIVE: last_line = (line_q == LINE_W'(V_ACTIVE - 1));
      ST_VFP:    last_line = (line_q == LINE_W'(V_FP - 1));
      default:   last_line = 1'b0;
    endcase
  end

  // Next state and counters; a frame always runs to the end of VFP once started
  always_comb begin
    state_nxt = state_q;
    col_nxt   = col_q;
    line_nxt  = line_q;
    if (state_q == ST_IDLE) begin
      col_nxt  = '0;
      line_nxt = '0;
      if (enable) state_nxt = ST_VSYNC;
    end else if (eol) begin
      col_nxt = '0;
      if (last_line) begin
        line_nxt = '0;
        case (state_q)
          ST_VSYNC:  state_nxt = ST_VBP;
          ST_VBP:    state_nxt = ST_ACTIVE;
          ST_ACTIVE: state_nxt = ST_VFP;
          ST_VFP:    state_nxt = enable ? ST_VSYNC : ST_IDLE;
          default:   state_nxt = ST_IDLE;
        endcase
      end else begin
        line_nxt = line_q + LINE_W'(1);
      end
    end else begin
      col_nxt = col_q + COL_W'(1);
    end
  end

  // Outputs are derived from next-cycle counters so registers line up with the state
  assign sel_load = (state_nxt == ST_VSYNC) && (state_q != ST_VSYNC);
  assign href_nxt = (state_nxt == ST_ACTIVE) && (col_nxt < COL_W'(HREF_LEN));
  assign done_nxt = (state_nxt == ST_VFP) && (line_nxt == LINE_W'(V_FP - 1)) &&
                    (col_nxt == COL_W'(LINE_LEN - 1));
  assign x_nxt    = PXW'(col_nxt >> 1);
  assign y_nxt    = PYW'(line_nxt);
  assign data_nxt = !href_nxt ? 8'h00 : (col_nxt[0] ? pixel_c[7:0] : pixel_c[15:8]);

  dvp_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (PXW),
    .YW       (PYW)
  ) u_pattern (
    .sel         (sel_q),
    .x           (x_nxt),
    .y           (y_nxt),
    .frame_count (frame_count),
    .pixel_c     (pixel_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q       <= '0;
      line_q      <= '0;
      sel_q       <= PAT_BARS;
      cam_vsync   <= 1'b0;
      cam_href    <= 1'b0;
      cam_data    <= 8'h00;
      frame_done  <= 1'b0;
      frame_count <= 8'h00;
    end else begin
      col_q      <= col_nxt;
      line_q     <= line_nxt;
      cam_vsync  <= (state_nxt == ST_VSYNC);
      cam_href   <= href_nxt;
      cam_data   <= data_nxt;
      frame_done <= done_nxt;
      if (sel_load)   sel_q       <= pattern_sel;
      if (frame_done) frame_count <= frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_dvp_frame_gen.sv
// Directed bench for dvp_frame_gen: a reduced-timing instance for frame/pattern
// checks and a tiny-frame instance for the 257-frame frame-ID wrap.
module tb_dvp_frame_gen;

  localparam int HA = 64, VA = 34, HB = 8, VS = 2, VBPL = 1, VFPL = 2;
  localparam int L = 2 * HA + HB;                     // 136
  localparam int FRAME = (VS + VBPL + VA + VFPL) * L; // 5304
  localparam int SFRAME = 4 * 18;                     // tiny instance: 72

  logic       clk = 1'b0;
  logic       reset, enable, enable_s;
  logic [1:0] pattern_sel, sel_s;
  logic       cam_vsync, cam_href, frame_done;
  logic [7:0] cam_data, frame_count;
  logic       cam_vsync_s, cam_href_s, frame_done_s;
  logic [7:0] cam_data_s, frame_count_s;

  int tests = 0, fails = 0;
  int vs_cnt, href_pulses, href_min, href_max, blank_err, fd_cnt, fd_idx;
  logic [7:0] fb [VA][2*HA];

  always #5 clk = ~clk;

  dvp_frame_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
                  .V_SYNC(VS), .V_BP(VBPL), .V_FP(VFPL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .frame_done(frame_done), .frame_count(frame_count));

  dvp_frame_gen #(.H_ACTIVE(8), .V_ACTIVE(1), .H_BLANK(2),
                  .V_SYNC(1), .V_BP(1), .V_FP(1)) dut_s (
    .clk(clk), .reset(reset), .enable(enable_s), .pattern_sel(sel_s),
    .cam_vsync(cam_vsync_s), .cam_href(cam_href_s), .cam_data(cam_data_s),
    .frame_done(frame_done_s), .frame_count(frame_count_s));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] px(input int ln, input int p);
    return {fb[ln][2*p], fb[ln][2*p+1]};
  endfunction

  // Record one frame starting at its first vsync cycle; optionally drop enable at drop_at
  task automatic run_frame(input int drop_at);
    int ln = -1, b = 0, run = 0;
    logic prev = 1'b0;
    vs_cnt = 0; href_pulses = 0; href_min = 1 << 30; href_max = 0;
    blank_err = 0; fd_cnt = 0; fd_idx = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (i == drop_at) enable = 1'b0;
      if (cam_vsync) vs_cnt++;
      if (frame_done) begin fd_cnt++; fd_idx = i; end
      if (cam_href) begin
        if (!prev) begin href_pulses++; ln++; b = 0; run = 0; end
        if (ln >= 0 && ln < VA && b < 2*HA) fb[ln][b] = cam_data;
        b++; run++;
      end else begin
        if (prev) begin
          if (run < href_min) href_min = run;
          if (run > href_max) href_max = run;
        end
        if (cam_data !== 8'h00) blank_err++;
      end
      prev = cam_href;
      step();
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; enable = 1'b0; enable_s = 1'b0; pattern_sel = 2'b00; sel_s = 2'b11;
    repeat (3) step();
    tests++;
    if ({cam_vsync, cam_href, cam_data, frame_done, frame_count} !== 19'd0) begin
      fails++; $display("FAIL reset_outputs: got vs=%b href=%b data=%h fd=%b fc=%h, required all 0",
                        cam_vsync, cam_href, cam_data, frame_done, frame_count);
    end
    reset = 1'b1;
    repeat (20) step();
    tests++;
    if (cam_vsync !== 1'b0 || frame_count !== 8'd0) begin
      fails++; $display("FAIL idle_without_enable: vs=%b fc=%h, required 0 and 00", cam_vsync, frame_count);
    end
  endtask

  task automatic test_timing_bars;
    pattern_sel = 2'b00; enable = 1'b1;
    step();
    tests++;
    if (cam_vsync !== 1'b1) begin fails++; $display("FAIL start_latency: vsync=%b required 1", cam_vsync); end
    run_frame(-1);
    tests++; if (vs_cnt != VS*L) begin fails++; $display("FAIL vsync_len: got %0d required %0d", vs_cnt, VS*L); end
    tests++; if (href_pulses != VA) begin fails++; $display("FAIL href_pulses: got %0d required %0d", href_pulses, VA); end
    tests++; if (href_min != 2*HA || href_max != 2*HA) begin
      fails++; $display("FAIL href_len: got min %0d max %0d required %0d", href_min, href_max, 2*HA); end
    tests++; if (blank_err != 0) begin fails++; $display("FAIL blank_data: %0d nonzero bytes, required 0", blank_err); end
    tests++; if (fd_cnt != 1 || fd_idx != FRAME-1) begin
      fails++; $display("FAIL frame_done_pos: count %0d at %0d, required 1 at %0d", fd_cnt, fd_idx, FRAME-1); end
    tests++; if (px(0,0) !== 16'hFFFF) begin fails++; $display("FAIL bars_px0: got %h required FFFF", px(0,0)); end
    tests++; if (px(0,7) !== 16'hFFFF) begin fails++; $display("FAIL bars_px7: got %h required FFFF", px(0,7)); end
    tests++; if (px(0,8) !== 16'hFFE0) begin fails++; $display("FAIL bars_px8: got %h required FFE0", px(0,8)); end
    tests++; if (px(0,16) !== 16'h07FF) begin fails++; $display("FAIL bars_px16: got %h required 07FF", px(0,16)); end
    tests++; if (px(0,63) !== 16'h0000) begin fails++; $display("FAIL bars_px63: got %h required 0000", px(0,63)); end
    tests++; if (px(33,40) !== 16'hF800) begin fails++; $display("FAIL bars_l33_px40: got %h required F800", px(33,40)); end
    tests++; if (cam_vsync !== 1'b1 || frame_count !== 8'd1) begin
      fails++; $display("FAIL frame_period: vs=%b fc=%h, required 1 and 01", cam_vsync, frame_count); end
  endtask

  task automatic test_pattern_latch;
    pattern_sel = 2'b01;
    run_frame(-1);
    tests++; if (px(0,8) !== 16'hFFE0) begin fails++; $display("FAIL sel_midframe: got %h required FFE0", px(0,8)); end
    tests++; if (frame_count !== 8'd2) begin fails++; $display("FAIL fc_frame2: got %h required 02", frame_count); end
  endtask

  task automatic test_gradient;
    pattern_sel = 2'b10;
    run_frame(-1);
    tests++; if (px(0,16) !== 16'h0020) begin fails++; $display("FAIL grad_px16: got %h required 0020", px(0,16)); end
    tests++; if (px(0,32) !== 16'h0841) begin fails++; $display("FAIL grad_px32: got %h required 0841", px(0,32)); end
    tests++; if (px(5,63) !== 16'h0861) begin fails++; $display("FAIL grad_px63: got %h required 0861", px(5,63)); end
  endtask

  task automatic test_checker_enable_drop;
    pattern_sel = 2'b11;
    run_frame((VS + VBPL + 10) * L);
    tests++; if (px(0,32) !== 16'hFFFF) begin fails++; $display("FAIL chk_32_0: got %h required FFFF", px(0,32)); end
    tests++; if (px(0,0) !== 16'h0000) begin fails++; $display("FAIL chk_0_0: got %h required 0000", px(0,0)); end
    tests++; if (px(32,32) !== 16'h0000) begin fails++; $display("FAIL chk_32_32: got %h required 0000", px(32,32)); end
    tests++; if (px(32,0) !== 16'hFFFF) begin fails++; $display("FAIL chk_0_32: got %h required FFFF", px(32,0)); end
    tests++; if (blank_err != 0) begin fails++; $display("FAIL chk_blank: %0d nonzero bytes, required 0", blank_err); end
    tests++; if (vs_cnt != VS*L || href_pulses != VA || fd_cnt != 1) begin
      fails++; $display("FAIL drop_full_frame: vs %0d href %0d fd %0d, required %0d %0d 1", vs_cnt, href_pulses, fd_cnt, VS*L, VA); end
    tests++; if ({cam_vsync, cam_href, cam_data, frame_done} !== 11'd0 || frame_count !== 8'd4) begin
      fails++; $display("FAIL drop_idle: vs=%b href=%b data=%h fd=%b fc=%h, required 0 0 00 0 04",
                        cam_vsync, cam_href, cam_data, frame_done, frame_count); end
    repeat (50) step();
    tests++; if (cam_vsync !== 1'b0) begin fails++; $display("FAIL drop_stays_idle: vsync=%b required 0", cam_vsync); end
  endtask

  task automatic test_reset_mid;
    int bad = 0, n = 0;
    pattern_sel = 2'b00; enable = 1'b1;
    step();
    repeat (5*L + 10 - 1) step();
    tests++; if (cam_href !== 1'b1) begin fails++; $display("FAIL mid_active_href: got %b required 1", cam_href); end
    pattern_sel = 2'b10;
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({cam_vsync, cam_href, cam_data, frame_done, frame_count} !== 19'd0) begin
      fails++; $display("FAIL async_reset: vs=%b href=%b data=%h fd=%b fc=%h, required all 0",
                        cam_vsync, cam_href, cam_data, frame_done, frame_count);
    end
    repeat (5) begin step(); if (frame_done !== 1'b0 || cam_vsync !== 1'b0) bad++; end
    tests++; if (bad != 0) begin fails++; $display("FAIL reset_hold: %0d bad cycles, required 0", bad); end
    reset = 1'b1;
    while (cam_vsync !== 1'b1 && n < 100) begin step(); n++; end
    tests++; if (cam_vsync !== 1'b1) begin fails++; $display("FAIL restart_vsync: got %b required 1", cam_vsync); end
    run_frame(-1);
    enable = 1'b0;
    tests++; if (px(0,32) !== 16'hFFFF || px(32,32) !== 16'h0000) begin
      fails++; $display("FAIL relatch_sel: got %h %h required FFFF 0000", px(0,32), px(32,32)); end
    tests++; if (fd_cnt != 1 || frame_count !== 8'd1) begin
      fails++; $display("FAIL restart_count: fd %0d fc %h required 1 01", fd_cnt, frame_count); end
  endtask

  task automatic test_frame_id;
    int fd_err = 0, start_err = 0, fdf, c5 = 0;
    logic [7:0] fc0 = 8'hxx, fc254 = 8'hxx, fc255 = 8'hxx;
    logic [7:0] b5 [2];
    b5[0] = 8'hxx; b5[1] = 8'hxx;
    sel_s = 2'b11; enable_s = 1'b1;
    step();
    for (int f = 0; f < 257; f++) begin
      fdf = 0;
      for (int i = 0; i < SFRAME; i++) begin
        if (frame_done_s) fdf++;
        if (i == 0 && cam_vsync_s !== 1'b1) start_err++;
        if (f == 5 && cam_href_s && c5 < 2) begin b5[c5] = cam_data_s; c5++; end
        step();
      end
      if (fdf != 1) fd_err++;
      if (f == 0)   fc0   = frame_count_s;
      if (f == 254) fc254 = frame_count_s;
      if (f == 255) fc255 = frame_count_s;
    end
    enable_s = 1'b0;
    tests++; if (fd_err != 0) begin fails++; $display("FAIL fid_done_per_frame: %0d bad frames, required 0", fd_err); end
    tests++; if (start_err != 0) begin fails++; $display("FAIL fid_back_to_back: %0d late starts, required 0", start_err); end
    tests++; if (fc0 !== 8'd1) begin fails++; $display("FAIL fid_fc_first: got %h required 01", fc0); end
    tests++; if (fc254 !== 8'd255) begin fails++; $display("FAIL fid_fc_255: got %h required FF", fc254); end
    tests++; if (fc255 !== 8'd0) begin fails++; $display("FAIL fid_wrap: got %h required 00", fc255); end
    tests++; if (frame_count_s !== 8'd1) begin fails++; $display("FAIL fid_fc_final: got %h required 01", frame_count_s); end
    tests++; if (b5[0] !== 8'h05 || b5[1] !== 8'hFA) begin
      fails++; $display("FAIL fid_frame5: got %h %h required 05 FA", b5[0], b5[1]); end
  endtask

  initial begin
    test_reset();
    test_timing_bars();
    test_pattern_latch();
    test_gradient();
    test_checker_enable_drop();
    test_reset_mid();
    test_frame_id();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
